// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit
// Program-counter unit for the fetch stage. Holds the fetch address and picks
// the next PC from the trap, stall, return, call, jump, branch and sequential
// sources, in that priority order. A small circular return-address stack (RAS)
// stores return addresses for call/return pairs.
//
// Ports
//   Clk            in   rising-edge clock
//   Reset          in   asynchronous, active-low reset
//   Stall          in   hold PC and RAS this cycle (Trap still applies)
//   Branch_taken   in   take Branch_target
//   Branch_target  in   branch destination (word aligned internally)
//   Jump           in   take Jump_target
//   Call           in   take Jump_target and push Address+INC
//   Jump_target    in   jump/call destination (word aligned internally)
//   Ret            in   pop RAS top as next PC
//   Trap           in   force next PC to TRAP_VEC
//   Address        out  registered current PC
//   Next_address   out  combinational next-PC value
//   Ras_empty      out  RAS holds no entries
//   Ras_full       out  RAS holds RAS_DEPTH entries
//   Ras_underflow  out  one-cycle pulse after a Ret on an empty RAS
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(32'h0000_0080),
    parameter int                INC       = 4,
    parameter int                RAS_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Stall,
    input  logic              Branch_taken,
    input  logic [ADDR_W-1:0] Branch_target,
    input  logic              Jump,
    input  logic              Call,
    input  logic [ADDR_W-1:0] Jump_target,
    input  logic              Ret,
    input  logic              Trap,
    output logic [ADDR_W-1:0] Address,
    output logic [ADDR_W-1:0] Next_address,
    output logic              Ras_empty,
    output logic              Ras_full,
    output logic              Ras_underflow
);

    localparam int                PTR_W      = $clog2(RAS_DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
    // Clears the low log2(INC) bits so branch/jump targets are word aligned.
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(INC_V - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  FULL_CNT   = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rasMem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  rasPtr_q, rasPtr_d;
    logic [CNT_W-1:0]  rasCount_q, rasCount_d;
    logic              underflow_q, underflow_d;
    logic              push, pop;
    logic [ADDR_W-1:0] seqAddr;
    logic [ADDR_W-1:0] rasTop;
    logic [PTR_W-1:0]  topIdx;

    // rasPtr_q names the next slot to write, so the most recent push sits one
    // below it. Pointer arithmetic wraps naturally in PTR_W bits, which makes a
    // push on a full stack overwrite the oldest entry.
    assign seqAddr = addr_q + INC_V;
    assign topIdx  = rasPtr_q - PTR_W'(1);
    assign rasTop  = rasMem_q[topIdx];

    // Next-PC selection with fixed priority. Ret is checked before Call so a
    // simultaneous Call/Ret pops without pushing.
    always_comb begin
        addr_d      = seqAddr;
        push        = 1'b0;
        pop         = 1'b0;
        underflow_d = 1'b0;
        if (Trap) begin
            addr_d = TRAP_VEC;
        end else if (Stall) begin
            addr_d = addr_q;
        end else if (Ret) begin
            if (rasCount_q != '0) begin
                addr_d = rasTop;
                pop    = 1'b1;
            end else begin
                addr_d      = TRAP_VEC;
                underflow_d = 1'b1;
            end
        end else if (Call) begin
            addr_d = Jump_target & ALIGN_MASK;
            push   = 1'b1;
        end else if (Jump) begin
            addr_d = Jump_target & ALIGN_MASK;
        end else if (Branch_taken) begin
            addr_d = Branch_target & ALIGN_MASK;
        end
    end

    // RAS pointer and occupancy; the count saturates at RAS_DEPTH while the
    // pointer keeps advancing around the ring.
    always_comb begin
        rasPtr_d   = rasPtr_q;
        rasCount_d = rasCount_q;
        if (pop) begin
            rasPtr_d   = topIdx;
            rasCount_d = rasCount_q - CNT_W'(1);
        end else if (push) begin
            rasPtr_d = rasPtr_q + PTR_W'(1);
            if (rasCount_q != FULL_CNT) begin
                rasCount_d = rasCount_q + CNT_W'(1);
            end
        end
    end

    // State registers; the stack storage is cleared too so no X can reach
    // Next_address through a stale entry.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            addr_q      <= RESET_VEC;
            rasPtr_q    <= '0;
            rasCount_q  <= '0;
            underflow_q <= 1'b0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                rasMem_q[i] <= '0;
            end
        end else begin
            addr_q      <= addr_d;
            rasPtr_q    <= rasPtr_d;
            rasCount_q  <= rasCount_d;
            underflow_q <= underflow_d;
            if (push) begin
                rasMem_q[rasPtr_q] <= seqAddr;
            end
        end
    end

    assign Address       = addr_q;
    assign Next_address  = addr_d;
    assign Ras_empty     = (rasCount_q == '0);
    assign Ras_full      = (rasCount_q == FULL_CNT);
    assign Ras_underflow = underflow_q;

endmodule
